// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: output pins with write/set/clear/toggle access,
// synchronised input pins, rising-edge capture and a level interrupt.
module mmio_gpio #(
  parameter logic [31:0]      BASE_ADDR = 32'd1024,
  parameter int               WIDTH     = 6,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] INVERT    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_en,
  input  logic             mem_read,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             sel,
  output logic [WIDTH-1:0] gpio_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  typedef logic [WIDTH-1:0] vec_t;

  logic       hit;
  logic       wr;
  logic       rd;
  logic [2:0] idx;
  vec_t       d;
  vec_t       sync1_q;
  vec_t       sync_q;
  vec_t       prev_q;
  vec_t       rise;
  vec_t       out_q;
  vec_t       out_d;
  vec_t       ien_q;
  vec_t       ien_d;
  vec_t       stat_q;
  vec_t       stat_d;
  vec_t       w1c;
  vec_t       rd_val;
  logic [31:0] rd_word;
  logic [31:0] rdata_q;
  logic       sel_q;
  logic       irq_q;
  logic       unused_bits;

  assign hit = mem_en && (addr[31:5] == BASE_ADDR[31:5]);
  assign wr  = hit && !mem_read;
  assign rd  = hit && mem_read;
  assign idx = addr[4:2];
  assign d   = wdata[WIDTH-1:0];

  assign unused_bits = ^{addr[1:0], wdata};

  assign rise = sync_q & ~prev_q;

  always_comb begin
    out_d  = out_q;
    ien_d  = ien_q;
    w1c    = '0;
    rd_val = '0;
    unique case (idx)
      3'd0: begin
        rd_val = out_q;
        if (wr) out_d = d;
      end
      3'd1: begin
        rd_val = out_q;
        if (wr) out_d = out_q | d;
      end
      3'd2: begin
        rd_val = out_q;
        if (wr) out_d = out_q & ~d;
      end
      3'd3: begin
        rd_val = out_q;
        if (wr) out_d = out_q ^ d;
      end
      3'd4: rd_val = sync_q;
      3'd5: begin
        rd_val = ien_q;
        if (wr) ien_d = d;
      end
      3'd6: begin
        rd_val = stat_q;
        if (wr) w1c = d;
      end
      3'd7: rd_val = '0;
    endcase
    // a fresh edge beats a concurrent clear so no event is lost
    stat_d = (stat_q & ~w1c) | rise;
    rd_word = '0;
    rd_word[WIDTH-1:0] = rd_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= RESET_VAL;
      ien_q   <= '0;
      stat_q  <= '0;
      sync1_q <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      sync1_q <= gpio_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
      rdata_q <= rd ? rd_word : 32'd0;
      sel_q   <= rd;
      irq_q   <= |(stat_q & ien_q);
    end
  end

  assign gpio_out = out_q ^ INVERT;
  assign rdata    = rdata_q;
  assign sel      = sel_q;
  assign irq      = irq_q;

endmodule
